// File: rtl/modulo_entrada_ataque.sv
// Player input and attack write path: debounced buttons, attack cursor and shot classifier.
// Build option REPEAT_FLAG_EN: a shot on an already-attacked cell reports status 11.
module modulo_entrada_ataque #(
    parameter int unsigned DEB_CYCLES = 16,
    parameter int unsigned TOTAL_HITS = 5
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        btn_lin,
    input  logic        btn_col,
    input  logic        btn_fire,
    input  logic [34:0] navios,
    output logic [5:0]  coord_at,
    output logic [34:0] m_at,
    output logic [1:0]  status,
    output logic        fire_ack,
    output logic [3:0]  acertos,
    output logic        fim
);

    localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] LP_CNT_MAX = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] LP_CNT_ONE = CW'(1);
    localparam logic [3:0]    LP_TOTAL   = 4'(TOTAL_HITS);
    localparam logic [1:0]    LP_WATER   = 2'b01;
    localparam logic [1:0]    LP_HIT     = 2'b10;
    localparam logic [1:0]    LP_REPEAT  = 2'b11;
    localparam logic [2:0]    LP_ROW_MAX = 3'd4;
    localparam logic [2:0]    LP_COL_MAX = 3'd6;
    localparam int unsigned   IDX_LIN    = 0;
    localparam int unsigned   IDX_COL    = 1;
    localparam int unsigned   IDX_FIRE   = 2;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StUpd,
        StFim
    } state_t;

    // ------------------------------------------------------------------
    // Button conditioning: synchronizer, debounce, rising-edge pulse
    // ------------------------------------------------------------------
    logic [2:0]    w_btn;
    logic [2:0]    r_sync1;
    logic [2:0]    r_sync2;
    logic [2:0]    r_sync3;
    logic [2:0]    r_acc;
    logic [2:0]    r_acc_d;
    logic [CW-1:0] r_cnt [3];
    logic [2:0]    w_pulse;
    logic          w_p_lin;
    logic          w_p_col;
    logic          w_p_fire;

    assign w_btn = {btn_fire, btn_col, btn_lin};

    // r_sync3 holds the previous synchronized sample so a level change restarts the count
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
            r_acc   <= '0;
            r_acc_d <= '0;
            for (int i = 0; i < 3; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_acc_d <= r_acc;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] != r_sync3[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] != LP_CNT_MAX) begin
                    r_cnt[i] <= r_cnt[i] + LP_CNT_ONE;
                end else begin
                    r_acc[i] <= r_sync3[i];
                end
            end
        end
    end

    assign w_pulse  = r_acc & ~r_acc_d;
    assign w_p_lin  = w_pulse[IDX_LIN];
    assign w_p_col  = w_pulse[IDX_COL];
    assign w_p_fire = w_pulse[IDX_FIRE];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    state_t r_state;
    state_t w_state_nxt;
    logic   w_latch;
    logic   w_commit;
    logic   w_fim_set;
    logic   w_move_en;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_commit    = 1'b0;
        w_fim_set   = 1'b0;
        w_move_en   = 1'b1;
        unique case (r_state)
            StIdle: begin
                if (w_p_fire) begin
                    w_latch     = 1'b1;
                    w_state_nxt = StCalc;
                end
            end
            StCalc: begin
                // Classification is committed on this edge so results show up while in UPD
                w_commit    = 1'b1;
                w_state_nxt = StUpd;
            end
            StUpd: begin
                if (acertos == LP_TOTAL) begin
                    w_fim_set   = 1'b1;
                    w_state_nxt = StFim;
                end else begin
                    w_state_nxt = StIdle;
                end
            end
            StFim: begin
                w_move_en = 1'b0;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Cursor
    // ------------------------------------------------------------------
    logic [2:0] r_row;
    logic [2:0] r_col;
    logic [2:0] w_row_nxt;
    logic [2:0] w_col_nxt;
    logic [2:0] r_lat_row;
    logic [2:0] r_lat_col;

    always_comb begin
        w_row_nxt = r_row;
        w_col_nxt = r_col;
        if (w_move_en && w_p_lin) begin
            w_row_nxt = (r_row == LP_ROW_MAX) ? 3'd0 : r_row + 3'd1;
        end
        if (w_move_en && w_p_col) begin
            w_col_nxt = (r_col == LP_COL_MAX) ? 3'd0 : r_col + 3'd1;
        end
    end

    // The shot uses the cursor as it was before any move in the same cycle
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_row     <= '0;
            r_col     <= '0;
            r_lat_row <= '0;
            r_lat_col <= '0;
        end else begin
            r_row <= w_row_nxt;
            r_col <= w_col_nxt;
            if (w_latch) begin
                r_lat_row <= r_row;
                r_lat_col <= r_col;
            end
        end
    end

    // ------------------------------------------------------------------
    // Shot classification and attack matrix
    // ------------------------------------------------------------------
    logic [5:0]  w_cell;
    logic [5:0]  w_idx;
    logic        w_atk;
    logic        w_shp;
    logic [34:0] r_m_at;
    logic [34:0] w_m_at_nxt;
    logic [1:0]  r_status;
    logic [1:0]  w_status_nxt;
    logic [3:0]  r_acertos;
    logic [3:0]  w_acertos_nxt;
    logic        r_fire_ack;
    logic        r_fim;

    assign w_cell = ({3'b000, r_lat_col} * 6'd5) + {3'b000, r_lat_row};
    assign w_idx  = 6'd34 - w_cell;
    assign w_atk  = r_m_at[w_idx];
    assign w_shp  = navios[w_idx];

    always_comb begin
        w_m_at_nxt    = r_m_at;
        w_status_nxt  = r_status;
        w_acertos_nxt = r_acertos;
        if (w_commit) begin
            if (!w_atk) begin
                w_m_at_nxt[w_idx] = 1'b1;
                w_status_nxt      = w_shp ? LP_HIT : LP_WATER;
                if (w_shp && (r_acertos != 4'hF)) begin
                    w_acertos_nxt = r_acertos + 4'd1;
                end
            end else begin
`ifdef REPEAT_FLAG_EN
                w_status_nxt = LP_REPEAT;
`else
                w_status_nxt = w_shp ? LP_HIT : LP_WATER;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_m_at     <= '0;
            r_status   <= '0;
            r_acertos  <= '0;
            r_fire_ack <= 1'b0;
            r_fim      <= 1'b0;
        end else begin
            r_m_at     <= w_m_at_nxt;
            r_status   <= w_status_nxt;
            r_acertos  <= w_acertos_nxt;
            r_fire_ack <= w_commit;
            if (w_fim_set) begin
                r_fim <= 1'b1;
            end
        end
    end

`ifndef REPEAT_FLAG_EN
    logic w_unused;
    assign w_unused = ^LP_REPEAT;
`endif

    assign coord_at = {r_row, r_col};
    assign m_at     = r_m_at;
    assign status   = r_status;
    assign fire_ack = r_fire_ack;
    assign acertos  = r_acertos;
    assign fim      = r_fim;

endmodule

// File: tb/tb_modulo_entrada_ataque.sv
// Randomized self-checking bench for modulo_entrada_ataque against a press-level game model.
module tb_modulo_entrada_ataque;

    localparam int unsigned DEB      = 4;
    localparam int unsigned HITS     = 2;
    localparam int          LAT_MOVE = 2 + DEB + 1 + 1;
    localparam int          LAT_FIRE = 2 + DEB + 1 + 2;
    localparam int          SETTLE   = 20;

    logic        clk = 1'b0;
    logic        clr;
    logic        btn_lin;
    logic        btn_col;
    logic        btn_fire;
    logic [34:0] navios;
    logic [5:0]  coord_at;
    logic [34:0] m_at;
    logic [1:0]  status;
    logic        fire_ack;
    logic [3:0]  acertos;
    logic        fim;

    modulo_entrada_ataque #(
        .DEB_CYCLES (DEB),
        .TOTAL_HITS (HITS)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .btn_lin  (btn_lin),
        .btn_col  (btn_col),
        .btn_fire (btn_fire),
        .navios   (navios),
        .coord_at (coord_at),
        .m_at     (m_at),
        .status   (status),
        .fire_ack (fire_ack),
        .acertos  (acertos),
        .fim      (fim)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int t_rise   = 0;
    int ack_cnt  = 0;
    int ack_base = 0;
    int ack_lat  = -1;
    int mov_lat  = -1;
    int fim_lat  = -1;
    logic [5:0] coord_prev = '0;
    logic       fim_prev   = 1'b0;

    // Game model: cursor position, attacked cells, hits, last status
    int          m_row;
    int          m_col;
    logic [34:0] m_att;
    int          m_hits;
    int          m_status;
    int          m_acks;
    bit          m_fim;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (fire_ack) begin
            ack_cnt++;
            ack_lat = cyc - t_rise;
        end
        if (coord_at != coord_prev) mov_lat = cyc - t_rise;
        if (fim && !fim_prev) fim_lat = cyc - t_rise;
        coord_prev = coord_at;
        fim_prev   = fim;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_row    = 0;
        m_col    = 0;
        m_att    = '0;
        m_hits   = 0;
        m_status = 0;
        m_acks   = 0;
        m_fim    = 1'b0;
        ack_base = ack_cnt;
    endtask

    task automatic model_press(input int b);
        int k;
        if (m_fim) return;
        if (b == 0) m_row = (m_row + 1) % 5;
        else if (b == 1) m_col = (m_col + 1) % 7;
        else begin
            k = 34 - (m_col * 5 + m_row);
            if (!m_att[k]) begin
                m_att[k] = 1'b1;
                m_status = navios[k] ? 2 : 1;
                if (navios[k]) m_hits++;
            end else begin
`ifdef REPEAT_FLAG_EN
                m_status = 3;
`else
                m_status = navios[k] ? 2 : 1;
`endif
            end
            m_acks++;
            if (m_hits == HITS) m_fim = 1'b1;
        end
    endtask

    task automatic check_all(input string ctx);
        int sat;
        sat = (m_hits > 15) ? 15 : m_hits;
        check({ctx, ".coord"},   64'(coord_at), 64'({3'(m_row), 3'(m_col)}));
        check({ctx, ".m_at"},    64'(m_at), 64'(m_att));
        check({ctx, ".status"},  64'(status), 64'(m_status));
        check({ctx, ".acertos"}, 64'(acertos), 64'(sat));
        check({ctx, ".fim"},     64'(fim), 64'(m_fim));
        check({ctx, ".acks"},    64'(ack_cnt - ack_base), 64'(m_acks));
    endtask

    task automatic set_btn(input int b, input logic v);
        if (b == 0) btn_lin = v;
        else if (b == 1) btn_col = v;
        else btn_fire = v;
    endtask

    task automatic press(input int b, input int hold);
        @(negedge clk);
        t_rise = cyc;
        set_btn(b, 1'b1);
        repeat (hold) @(negedge clk);
        set_btn(b, 1'b0);
        repeat (SETTLE) @(negedge clk);
    endtask

    task automatic do_press(input int b, input string ctx);
        press(b, 8);
        model_press(b);
        check_all(ctx);
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b1;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int saved;
        int r;
        int b;
        clr      = 1'b1;
        btn_lin  = 1'b0;
        btn_col  = 1'b0;
        btn_fire = 1'b0;
        navios   = (35'd1 << 34) | (35'd1 << 21);
        repeat (3) @(negedge clk);
        model_reset();
        check_all("reset");
        clr = 1'b0;
        repeat (2) @(negedge clk);

        // Bouncing row button: one accepted press
        for (int i = 0; i < 10; i++) begin
            btn_lin = (i % 2 == 0);
            @(negedge clk);
        end
        btn_lin = 1'b1;
        repeat (20) @(negedge clk);
        btn_lin = 1'b0;
        repeat (SETTLE) @(negedge clk);
        model_press(0);
        check("bounce.coord_exact", 64'(coord_at), 64'(6'b001_000));
        check_all("bounce");

        press(1, 3);
        check_all("short_pulse");

        // Cursor wrap
        do_reset();
        do_press(0, "wrap.r1");
        check("wrap.move_latency", 64'(mov_lat), 64'(LAT_MOVE));
        for (int i = 0; i < 3; i++) do_press(0, "wrap.r");
        check("wrap.row4", 64'(coord_at[5:3]), 64'(4));
        do_press(0, "wrap.r5");
        for (int i = 0; i < 7; i++) do_press(1, "wrap.c");
        check("wrap.zero", 64'(coord_at), 64'(0));

        // Hit at (0,0)
        do_press(2, "hit00");
        check("hit00.m_at_exact", 64'(m_at), 64'(35'h4_0000_0000));
        check("hit00.status_exact", 64'(status), 64'(2));
        check("hit00.ack_latency", 64'(ack_lat), 64'(LAT_FIRE));

        // Repeat shot at (0,0)
        do_press(2, "repeat00");
`ifdef REPEAT_FLAG_EN
        check("repeat00.status_exact", 64'(status), 64'(3));
`else
        check("repeat00.status_exact", 64'(status), 64'(2));
`endif
        check("repeat00.acertos_exact", 64'(acertos), 64'(1));

        // Water at (1,0)
        do_press(0, "miss.mv");
        do_press(2, "miss10");
        check("miss10.status_exact", 64'(status), 64'(1));

        // Second ship at row 3, col 2 ends the game
        do_press(0, "end.mv");
        do_press(0, "end.mv");
        do_press(1, "end.mv");
        do_press(1, "end.mv");
        do_press(2, "end.hit");
        check("end.fim_exact", 64'(fim), 64'(1));
        check("end.fim_latency", 64'(fim_lat), 64'(LAT_FIRE + 1));

        do_press(0, "over.lin");
        do_press(1, "over.col");
        do_press(2, "over.fire");

        do_reset();
        check_all("clr_after_fim");

        // Async reset while the shot is in CALC
        do_press(0, "mid.mv");
        do_press(2, "mid.miss");
        @(negedge clk);
        t_rise   = cyc;
        btn_fire = 1'b1;
        repeat (LAT_FIRE - 1) @(negedge clk);
        saved    = ack_cnt;
        clr      = 1'b1;
        btn_fire = 1'b0;
        #1;
        check("mid.m_at_async", 64'(m_at), 64'(0));
        repeat (3) @(negedge clk);
        clr = 1'b0;
        model_reset();
        repeat (SETTLE) @(negedge clk);
        check("mid.no_ack", 64'(ack_cnt), 64'(saved));
        check_all("mid.after");
        do_press(2, "mid.idle_fire");

        // Randomized games
        for (int g = 0; g < 6; g++) begin
            @(negedge clk);
            navios = 35'({$urandom, $urandom});
            do_reset();
            for (int p = 0; p < 40; p++) begin
                r = $urandom_range(0, 9);
                b = (r < 4) ? 0 : (r < 8) ? 1 : 2;
                if ($urandom_range(0, 7) == 0) begin
                    press(b, $urandom_range(1, 3));
                    check_all("rnd.glitch");
                end else begin
                    press(b, $urandom_range(6, 12));
                    model_press(b);
                    check_all("rnd.press");
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
